lz77_bit_packer: RTL
====================

Name: lz77_bit_packer

Overview:
- Sits directly downstream of lz77_compressor.
- Accepts the compressor's serial bitstream (outputBit/outputValid/outputReady) and packs it MSB-first into bytes.
- Buffers the bytes in a small FIFO and presents a ready/valid byte stream with an end-of-stream marker to the output DMA/file writer.
- On flush, pads the final partial byte with zeros and reports the bit and byte totals.

Parameters:
- fifoDepth, 16: depth of the output byte FIFO; must be a power of two.
- fifoAddressBits, 4: log2(fifoDepth).

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  one-cycle pulse; clears counters and begins a new stream when idle
- busy  output  1  high from accepted start until done
- done  output  1  high after the final byte is consumed; held until next start
- bitIn  input  1  serial bit from compressor outputBit
- bitValid  input  1  bitIn qualifier
- bitReady  output  1  packer can accept a bit this cycle
- flush  input  1  end of bitstream (tie to compressor done); level or pulse
- outData  output  8  packed byte
- outValid  output  1  outData valid
- outReady  input  1  downstream accepts byte
- outLast  output  1  high with the final byte of the stream
- bitCount  output  32  bits accepted since start
- byteCount  output  32  bytes accepted by downstream since start

Behaviour:
- Reset values: busy=0, done=0, bitReady=0, outValid=0, outLast=0, outData=0, bitCount=0, byteCount=0. FIFO is empty, shift register is 0, bit index is 0, state is IDLE.
- States:
  - IDLE: start -> PACK; counters cleared.
  - PACK: accept bits; flush seen -> PAD.
  - PAD: if bit index != 0, write shifted partial byte (low bits zero) to FIFO when not full, then -> TRAIL (macro) or DRAIN.
  - TRAIL: see Optional Feature.
  - DRAIN: wait FIFO empty -> DONE.
  - DONE: done=1; start -> PACK with cleared counters.
- start while not IDLE/DONE is ignored.
- bitReady = (state==PACK) && FIFO not full. Fullness is checked conservatively, so a bit is never accepted without space for a potential byte write.
- Bit transfer occurs on bitValid && bitReady. The first bit of each byte lands in bit 7. bitCount increments by 1 per transfer, wrapping at 2^32.
- On the 8th bit the complete byte (including the current bit) is written to the FIFO at that same edge. Bit index returns to 0. Latency from 8th bit to outValid is 1 cycle.
- flush and a bit transfer in the same cycle: the bit is accepted first, then the flush is registered. flush is ignored outside PACK.
- FIFO is first-word-fall-through: outValid = !empty, and outData = head entry.
- Byte transfer occurs on outValid && outReady. byteCount increments per transfer. Simultaneous push and pop when full is not possible; simultaneous push and pop otherwise keeps the count unchanged.
- outLast is high on the last byte written in the stream (partial, final full, or last trailer byte), tracked per FIFO entry.
- Zero-bit stream with macro off: no byte is emitted, outLast never asserts, and the packer goes PAD -> DRAIN -> DONE.
- outData and outValid are stable while outValid && !outReady.
- rst_n low mid-stream: immediate clear of everything; buffered bytes are discarded.

Optional Feature:
- Macro LZ77_PACKER_TRAILER_EN.
- Defined: after PAD, TRAIL writes 4 bytes holding the final bitCount, least-significant first. outLast is on the 4th trailer byte; the zero-bit stream emits 4 zero bytes. Data bytes never carry outLast.
- Undefined: TRAIL state is absent; PAD goes straight to DRAIN.

Test Plan:
- Bits 1,0,1,1,0,0,1,0 then flush, outReady=1 -> one byte 0xB2 with outLast=1; bitCount=8, byteCount=1; done 1-3 cycles after the byte transfer.
- 11 bits of 1 then flush -> bytes 0xFF then 0xE0 (outLast on 0xE0); bitCount=11, byteCount=2.
- outReady=0 while streaming 200 bits -> bitReady drops after 16 bytes are buffered. Release outReady -> all 25 bytes arrive in order, with no loss or duplication.
- flush asserted in the same cycle as the 8th bit of 0x5A -> exactly one byte 0x5A with outLast; no padding byte.
- Reset asserted mid-stream with 5 bytes buffered -> all outputs are 0 next sample; a new start with 8 zero bits and flush -> single 0x00 byte.
- With LZ77_PACKER_TRAILER_EN, 11 bits of 1 then flush -> bytes FF,E0,0B,00,00,00 with outLast only on the 6th; byteCount=6.

Source files
------------

// File: rtl/lz77_bit_packer.sv
// rtl/lz77_bit_packer.sv - packs a serial LZ77 bitstream MSB-first into a FIFO-buffered byte stream.
// Optional LZ77_PACKER_TRAILER_EN appends the 32-bit bit total as four trailer bytes.
module lz77_bit_packer #(
    parameter int fifoDepth       = 16,
    parameter int fifoAddressBits = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic        busy,
    output logic        done,
    input  logic        bitIn,
    input  logic        bitValid,
    output logic        bitReady,
    input  logic        flush,
    output logic [7:0]  outData,
    output logic        outValid,
    input  logic        outReady,
    output logic        outLast,
    output logic [31:0] bitCount,
    output logic [31:0] byteCount
);

`ifdef LZ77_PACKER_TRAILER_EN
    typedef enum logic [2:0] {IDLE, PACK, PAD, TRAIL, DRAIN, DONE} state_t;
`else
    typedef enum logic [2:0] {IDLE, PACK, PAD, DRAIN, DONE} state_t;
`endif

    state_t state, state_next;

    logic [7:0]                 mem_data [fifoDepth];
    logic                       mem_last [fifoDepth];
    logic [fifoAddressBits-1:0] wr_ptr, rd_ptr, newest;
    logic [fifoAddressBits:0]   count;
    logic                       full, empty;

    logic [7:0] shift_reg, shift_next;
    logic [2:0] bit_idx;
    logic [1:0] trail_idx;

    logic       bit_fire, byte_done, pop, clear, mark_now;
    logic       push, push_last;
    logic [7:0] push_data;

    // Depth is a power of two and count never exceeds it, so the top bit alone means full.
    assign full  = count[fifoAddressBits];
    assign empty = (count == '0);
    assign newest = wr_ptr - fifoAddressBits'(1);

    assign bitReady  = (state == PACK) && !full;
    assign bit_fire  = bitValid && bitReady;
    assign byte_done = bit_fire && (bit_idx == 3'd7);
    assign outValid  = !empty;
    assign pop       = outValid && outReady;
    assign outData   = empty ? 8'h00 : mem_data[rd_ptr];
    assign clear     = ((state == IDLE) || (state == DONE)) && start;
    assign busy      = (state != IDLE) && (state != DONE);
    assign done      = (state == DONE);

    // A flush landing on a byte boundary retro-marks the newest buffered byte as last;
    // the combinational term covers the case where that byte is leaving this very cycle.
`ifdef LZ77_PACKER_TRAILER_EN
    assign mark_now = 1'b0;
`else
    assign mark_now = (state == PACK) && flush && !bit_fire && (bit_idx == 3'd0) && !empty;
`endif
    assign outLast = !empty && (mem_last[rd_ptr] || (mark_now && (rd_ptr == newest)));

    always_comb begin
        shift_next = shift_reg;
        shift_next[3'd7 - bit_idx] = bitIn;
    end

    always_comb begin
        push      = 1'b0;
        push_data = 8'h00;
        push_last = 1'b0;
        case (state)
            PACK: begin
                if (byte_done) begin
                    push      = 1'b1;
                    push_data = {shift_reg[7:1], bitIn};
`ifndef LZ77_PACKER_TRAILER_EN
                    push_last = flush;
`endif
                end
            end
            PAD: begin
                if ((bit_idx != 3'd0) && !full) begin
                    push      = 1'b1;
                    push_data = shift_reg;
`ifndef LZ77_PACKER_TRAILER_EN
                    push_last = 1'b1;
`endif
                end
            end
`ifdef LZ77_PACKER_TRAILER_EN
            TRAIL: begin
                if (!full) begin
                    push      = 1'b1;
                    push_data = bitCount[{trail_idx, 3'b000} +: 8];
                    push_last = (trail_idx == 2'd3);
                end
            end
`endif
            default: ;
        endcase
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (start) state_next = PACK;
            PACK:  if (flush) state_next = PAD;
            PAD: begin
                if ((bit_idx == 3'd0) || !full) begin
`ifdef LZ77_PACKER_TRAILER_EN
                    state_next = TRAIL;
`else
                    state_next = DRAIN;
`endif
                end
            end
`ifdef LZ77_PACKER_TRAILER_EN
            TRAIL: if (!full && (trail_idx == 2'd3)) state_next = DRAIN;
`endif
            DRAIN: if (empty) state_next = DONE;
            DONE:  if (start) state_next = PACK;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            shift_reg <= 8'h00;
            bit_idx   <= 3'd0;
            trail_idx <= 2'd0;
            bitCount  <= 32'd0;
            byteCount <= 32'd0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
        end else begin
            state <= state_next;
            if (clear) begin
                shift_reg <= 8'h00;
                bit_idx   <= 3'd0;
                trail_idx <= 2'd0;
                bitCount  <= 32'd0;
                byteCount <= 32'd0;
            end else begin
                if (bit_fire) begin
                    shift_reg <= byte_done ? 8'h00 : shift_next;
                    bit_idx   <= bit_idx + 3'd1;
                    bitCount  <= bitCount + 32'd1;
                end else if ((state == PAD) && push) begin
                    shift_reg <= 8'h00;
                    bit_idx   <= 3'd0;
                end
                if (pop) byteCount <= byteCount + 32'd1;
`ifdef LZ77_PACKER_TRAILER_EN
                if ((state == TRAIL) && push) trail_idx <= trail_idx + 2'd1;
`endif
            end
            if (push) wr_ptr <= wr_ptr + fifoAddressBits'(1);
            if (pop)  rd_ptr <= rd_ptr + fifoAddressBits'(1);
            case ({push, pop})
                2'b10:   count <= count + (fifoAddressBits+1)'(1);
                2'b01:   count <= count - (fifoAddressBits+1)'(1);
                default: ;
            endcase
        end
    end

    // Storage carries no reset; empty gating hides stale entries.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wr_ptr] <= push_data;
            mem_last[wr_ptr] <= push_last;
        end
        if (mark_now) mem_last[newest] <= 1'b1;
    end

endmodule
